// File: rtl/vx_cache_victim_sel.sv
// Victim-way selector for a set-associative cache: prefers a free (invalid,
// unlocked) way, otherwise scans for an unlocked way from a PRNG-chosen start.
module vx_cache_victim_sel #(
    parameter int NUM_WAYS  = 4,
    parameter int NBITS     = 8,
    parameter int TAG_WIDTH = 4,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NBITS-1:0]     rnd_num,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NUM_WAYS-1:0]  req_valid_mask,
    input  logic [NUM_WAYS-1:0]  req_lock_mask,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WAY_BITS-1:0]  rsp_way,
    output logic                 rsp_evict,
    output logic                 rsp_fail,
    output logic [TAG_WIDTH-1:0] rsp_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [NUM_WAYS-1:0]   vmask_reg, vmask_next;
    logic [NUM_WAYS-1:0]   lmask_reg, lmask_next;
    logic [TAG_WIDTH-1:0]  tag_reg, tag_next;
    logic [WAY_BITS-1:0]   idx_reg, idx_next;
    logic [WAY_BITS-1:0]   cnt_reg, cnt_next;
    logic [WAY_BITS-1:0]   way_reg, way_next;
    logic                  evict_reg, evict_next;
    logic                  fail_reg, fail_next;

    logic [NUM_WAYS-1:0]   free_mask;
    logic                  free_any;
    logic [WAY_BITS-1:0]   free_way;

    // Lowest-index free way; descending loop lets the lowest set bit win.
    always_comb begin
        free_mask = ~vmask_reg & ~lmask_reg;
        free_any  = |free_mask;
        free_way  = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_way = WAY_BITS'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        vmask_next = vmask_reg;
        lmask_next = lmask_reg;
        tag_next   = tag_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        way_next   = way_reg;
        evict_next = evict_reg;
        fail_next  = fail_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    vmask_next = req_valid_mask;
                    lmask_next = req_lock_mask;
                    tag_next   = req_tag;
                    idx_next   = rnd_num[WAY_BITS-1:0];
                    cnt_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // cnt is zero only on the first scan cycle, which alone may take a free way.
                if (cnt_reg == '0 && free_any) begin
                    way_next   = free_way;
                    evict_next = 1'b0;
                    fail_next  = 1'b0;
                    state_next = RESP;
                end else if (!lmask_reg[idx_reg]) begin
                    way_next   = idx_reg;
                    evict_next = vmask_reg[idx_reg];
                    fail_next  = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == WAY_BITS'(NUM_WAYS - 1)) begin
                    way_next   = '0;
                    evict_next = 1'b0;
                    fail_next  = 1'b1;
                    state_next = RESP;
                end else begin
                    idx_next = idx_reg + 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            vmask_reg <= '0;
            lmask_reg <= '0;
            tag_reg   <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            way_reg   <= '0;
            evict_reg <= 1'b0;
            fail_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            vmask_reg <= vmask_next;
            lmask_reg <= lmask_next;
            tag_reg   <= tag_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            way_reg   <= way_next;
            evict_reg <= evict_next;
            fail_reg  <= fail_next;
        end
    end

    assign rsp_way   = way_reg;
    assign rsp_evict = evict_reg;
    assign rsp_fail  = fail_reg;
    assign rsp_tag   = tag_reg;

endmodule

// File: doc/vx_cache_victim_sel.md
Name: vx_cache_victim_sel

Overview:
- Consumer end of the cache pseudo-random number stream.
- Takes a per-set replacement request and returns the victim way index.
- Preference order: an invalid unlocked way first, then a random unlocked way picked by scanning from a PRNG-supplied start index.
- Sits between the cache tag-access stage and the fill/evict logic; uses valid/ready handshakes on both sides.

Parameters:
- NUM_WAYS, 4, associativity; power of 2, at least 2.
- NBITS, 8, width of the random input; must be at least log2(NUM_WAYS).
- TAG_WIDTH, 4, width of the opaque request ID carried through to the response.
- WAY_BITS, log2(NUM_WAYS), derived; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rnd_num  in  NBITS  free-running random value from the PRNG; sampled only on request accept.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_valid_mask  in  NUM_WAYS  bit w=1 means way w holds valid data.
- req_lock_mask  in  NUM_WAYS  bit w=1 means way w is not evictable (pending fill or pinned).
- req_tag  in  TAG_WIDTH  request ID.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts the response.
- rsp_way  out  WAY_BITS  selected victim way.
- rsp_evict  out  1  1 means the victim holds valid data and needs writeback/invalidate.
- rsp_fail  out  1  1 means every way is locked; no victim; requester must retry.
- rsp_tag  out  TAG_WIDTH  echo of req_tag.

Behaviour:
- States: IDLE, SCAN, RESP. Reset (synchronous) forces IDLE regardless of the current state; any in-flight request is dropped, not answered.
- Reset values:
  - req_ready=1 (combinational from IDLE).
  - rsp_valid=0, rsp_way=0, rsp_evict=0, rsp_fail=0, rsp_tag=0.
  - Internal idx=0, cnt=0.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready: register valid_mask, lock_mask and tag; set idx=rnd_num[WAY_BITS-1:0] and cnt=0; go to SCAN.
- SCAN (req_ready=0). Evaluate in priority order each cycle:
  - (a) First SCAN cycle only: if the free set F = ~valid_mask & ~lock_mask is non-zero, pick the lowest-index set bit of F; rsp_evict=0, rsp_fail=0; go to RESP.
  - (b) Else if lock_mask[idx]==0: rsp_way=idx, rsp_evict=valid_mask[idx], rsp_fail=0; go to RESP.
  - (c) Else if cnt==NUM_WAYS-1: rsp_fail=1, rsp_way=0, rsp_evict=0; go to RESP.
  - (d) Else: idx=(idx+1) mod NUM_WAYS (natural WAY_BITS wrap), cnt=cnt+1; stay in SCAN.
- RESP:
  - rsp_valid=1; rsp_way, rsp_evict, rsp_fail and rsp_tag are held stable while rsp_valid&&!rsp_ready.
  - On rsp_ready: go to IDLE. The next request can be accepted in the following cycle (no same-cycle turnaround).
- Latency, from the accept edge at cycle T:
  - Free way, or unlocked start index: rsp_valid asserted at T+2.
  - Each locked way skipped adds 1 cycle.
  - All locked: rsp_fail response at T+1+NUM_WAYS.
- Only the masks registered on accept are used. Changes on req_* inputs after accept are ignored.
- Upper bits rnd_num[NBITS-1:WAY_BITS] are ignored. rnd_num is ignored outside the accept cycle.
- Throughput: at most one request in flight; no queueing.

Test Plan:
- Reset mid-SCAN (NUM_WAYS=4, lock=4'b1111, reset asserted at T+2) -> next cycle IDLE, rsp_valid=0, req_ready=1; no response ever issued for that tag.
- Free way present: valid=4'b1011, lock=4'b0000, rnd_num=8'h03, tag=5 -> rsp_valid at T+2, way=2, evict=0, fail=0, tag=5.
- Random start unlocked: valid=4'b1111, lock=0, rnd_num=8'hA6 (low bits 2) -> way=2, evict=1 at T+2; upper rnd bits have no effect.
- Wrap-around skip: valid=4'b1111, lock=4'b1001, rnd_num=8'h03 -> idx 3 locked, wraps to 0 (locked), then 1 -> way=1, evict=1, rsp_valid at T+4.
- All locked: lock=4'b1111, any rnd -> rsp_valid at T+5 with fail=1, way=0, evict=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP, toggle req_* inputs meanwhile -> outputs stable, req_ready=0; after the rsp_ready pulse, req_ready=1 the next cycle and a back-to-back request is accepted.
